config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, bitstream word width in bits.
REQ-002 SHALL have parameter CHAIN_LENGTH, default 1024, total configuration bits in the downstream chain.
REQ-003 SHALL have parameter CNT_W, default $clog2(CHAIN_LENGTH+1), bit-counter width.
REQ-004 SHALL have one clock and a synchronous, active-high reset: config_clk  input  1  clock shared with the configuration chain.
REQ-005 config_rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  begin a load from IDLE or DONE.
REQ-007 word_in  input  WORD_WIDTH  bitstream word, MSB shifted first.
REQ-008 word_valid  input  1  word_in valid.
REQ-009 word_ready  output  1  loader accepts word this cycle.
REQ-010 cfg_data  output  1  serial bit driving the chain head's config_in.
REQ-011 cfg_en  output  1  shift enable driving the chain's config_en.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  all CHAIN_LENGTH bits shifted.
REQ-014 crc_out  output  8  CRC of shifted bits (see Configuration).

Function
REQ-015 SHALL implement states IDLE, LOAD, SHIFT, DONE in a registered state machine.
REQ-016 IDLE/DONE: start=1 -> LOAD next cycle, bit counter cleared to 0, done cleared.
REQ-017 LOAD: word_ready=1; word_valid=1 -> word captured into shift register, go to SHIFT; word_valid=0 -> remain in LOAD.
REQ-018 word_ready SHALL be 0 in every state except LOAD; word_valid outside LOAD is ignored.
REQ-019 SHIFT: each cycle cfg_en=1, cfg_data=current MSB of shift register, register shifts left, counter increments.
REQ-020 SHIFT lasts min(WORD_WIDTH, CHAIN_LENGTH - counter) cycles; then LOAD if counter<CHAIN_LENGTH, else DONE.
REQ-021 Final partial word: only remaining high-order bits shifted; low-order bits discarded.
REQ-022 cfg_en SHALL be 0 in IDLE, LOAD, DONE; cfg_data SHALL be 0 when cfg_en=0.
REQ-023 cfg_en and cfg_data SHALL be registered outputs; total cfg_en-high cycles per load exactly CHAIN_LENGTH.
REQ-024 busy=1 in LOAD and SHIFT; done=1 in DONE, held until start or reset.
REQ-025 start while busy SHALL be ignored.
REQ-026 Throughput: one word per WORD_WIDTH+1 cycles when word_valid held high.

Reset
REQ-027 config_rst SHALL force IDLE, counter 0, shift register 0, crc 0; outputs word_ready, cfg_data, cfg_en, busy, done all 0 after the reset edge.
REQ-028 Reset mid-load SHALL abort; cfg_en low on the next cycle; chain contents then undefined; next start reloads from bit 0.

Configuration
REQ-029 Macro CONFIG_LOADER_CRC_EN defined: crc_out = CRC-8, poly 0x07, init 0x00, no reflection, updated with cfg_data on every cfg_en cycle, cleared on start; stable in DONE.
REQ-030 Macro CONFIG_LOADER_CRC_EN undefined: no CRC logic; crc_out tied to 0.

Structure
REQ-031 Shared package SHALL hold the state encoding type, CRC-8 polynomial constant 0x07 and CRC init constant.
REQ-032 One sub-module config_crc8 (serial bit-in CRC-8, enable, clear) SHALL exist, instantiated only under CONFIG_LOADER_CRC_EN.
REQ-033 config_loader SHALL connect cfg_data/cfg_en to a chain of connector boxes' config_in/config_en with no glue logic.

Verification (WORD_WIDTH=8, CHAIN_LENGTH=20 unless stated)
REQ-034 Reset asserted 3 cycles -> all outputs 0, state IDLE, word_ready 0.
REQ-035 start, words 0xA5,0x3C,0xF0 back-to-back -> cfg_data 10100101 00111100 1111, cfg_en high exactly 20 cycles, done=1 after, low nibble 0x0 never shifted.
REQ-036 word_valid low 5 cycles between words -> cfg_en low during gap, word_ready high throughout gap, bit sequence identical to REQ-035.
REQ-037 config_rst after 10 shifted bits -> cfg_en 0 next cycle, busy 0; new start plus same words -> full 20-bit sequence from bit 0.
REQ-038 start pulsed during SHIFT and word_valid during IDLE -> no state change, no word accepted.
REQ-039 CRC_EN defined, CHAIN_LENGTH=8, word 0x01 -> crc_out=0x07 in DONE; all-zero word -> crc_out=0x00; undefined -> crc_out=0x00 always.

Source files
------------

// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration-chain loader:
// FSM state encoding and the CRC-8 parameters used by config_crc8.
package config_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/config_crc8.sv
// Serial bit-in CRC-8 (MSB-first, no reflection) with enable and
// synchronous clear; clear takes priority over enable.
module config_crc8
  import config_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic fb;

  assign fb = crc[7] ^ bit_in;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/config_loader.sv
// Word-to-serial loader for a configuration shift chain.
// Optional CRC-8 of the shifted bitstream when CONFIG_LOADER_CRC_EN is defined.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 1024,
  parameter int CNT_W        = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                  config_clk,
  input  logic                  config_rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  cfg_data,
  output logic                  cfg_en,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            crc_out
);

  localparam int BIDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [BIDX_W-1:0]       bidx, bidx_nx;
  logic [WORD_WIDTH-1:0]   shreg, shreg_nx;
  logic                    cfg_en_nx, cfg_data_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bidx_nx  = bidx;
    shreg_nx = shreg;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx = ST_LOAD;
          cnt_nx   = '0;
        end
      end
      ST_LOAD: begin
        if (word_valid) begin
          shreg_nx = word_in;
          bidx_nx  = '0;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_nx = shreg << 1;
        cnt_nx   = cnt + CNT_W'(1);
        bidx_nx  = bidx + BIDX_W'(1);
        // Chain end wins over word end, which drops the unused low bits.
        if (cnt == CNT_W'(CHAIN_LENGTH - 1)) begin
          state_nx = ST_DONE;
        end else if (bidx == BIDX_W'(WORD_WIDTH - 1)) begin
          state_nx = ST_LOAD;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Outputs are registered from next-state so they line up with SHIFT cycles.
    cfg_en_nx   = (state_nx == ST_SHIFT);
    cfg_data_nx = cfg_en_nx & shreg_nx[WORD_WIDTH-1];
  end

  always_ff @(posedge config_clk) begin
    if (config_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bidx     <= '0;
      shreg    <= '0;
      cfg_en   <= 1'b0;
      cfg_data <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bidx     <= bidx_nx;
      shreg    <= shreg_nx;
      cfg_en   <= cfg_en_nx;
      cfg_data <= cfg_data_nx;
    end
  end

  assign word_ready = (state == ST_LOAD);
  assign busy       = (state == ST_LOAD) || (state == ST_SHIFT);
  assign done       = (state == ST_DONE);

`ifdef CONFIG_LOADER_CRC_EN
  logic crc_clr;

  assign crc_clr = start && ((state == ST_IDLE) || (state == ST_DONE));

  config_crc8 u_crc (
    .clk    (config_clk),
    .rst    (config_rst),
    .clr    (crc_clr),
    .en     (cfg_en),
    .bit_in (cfg_data),
    .crc    (crc_out)
  );
`else
  assign crc_out = '0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: directed and randomized loads
// compared against a bit-queue / polynomial-division reference model.
`timescale 1ns/1ps
module tb_config_loader;

  localparam int W   = 8;
  localparam int CL  = 20;
  localparam int CL8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         config_rst = 1'b1;
  logic         start = 1'b0, word_valid = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         word_ready, cfg_data, cfg_en, busy, done;
  logic [7:0]   crc_out;

  logic         start_s = 1'b0, valid_s = 1'b0;
  logic [W-1:0] word_s = '0;
  logic         ready_s, data_s, en_s, busy_s, done_s;
  logic [7:0]   crc_s;

  config_loader #(.WORD_WIDTH(W), .CHAIN_LENGTH(CL)) dut (
    .config_clk(clk), .config_rst(config_rst), .start(start), .word_in(word_in),
    .word_valid(word_valid), .word_ready(word_ready), .cfg_data(cfg_data),
    .cfg_en(cfg_en), .busy(busy), .done(done), .crc_out(crc_out));

  config_loader #(.WORD_WIDTH(W), .CHAIN_LENGTH(CL8)) dut8 (
    .config_clk(clk), .config_rst(config_rst), .start(start_s), .word_in(word_s),
    .word_valid(valid_s), .word_ready(ready_s), .cfg_data(data_s),
    .cfg_en(en_s), .busy(busy_s), .done(done_s), .crc_out(crc_s));

  int n_checks = 0, n_fail = 0;
  bit got[$];
  bit exp_bits[$];
  logic [W-1:0] words[$];
  int busy_cycles, bad_data, bad_ready, gap_bad, timeouts;

  // Chain-side observer: collects every bit presented while cfg_en is high.
  always @(negedge clk) begin
    if (cfg_en === 1'b1) got.push_back(cfg_data);
    if (cfg_en !== 1'b1 && cfg_data !== 1'b0) bad_data++;
    if (busy === 1'b1) busy_cycles++;
    if (word_ready === 1'b1 && busy !== 1'b1) bad_ready++;
  end

  function automatic void build_exp(input int len);
    exp_bits.delete();
    foreach (words[i])
      for (int b = W - 1; b >= 0; b--)
        if (exp_bits.size() < len) exp_bits.push_back(words[i][b]);
  endfunction

  // Remainder of M(x)*x^8 mod (x^8+x^2+x+1).
  function automatic logic [7:0] crc_ref(input int n);
    bit m[$];
    logic [8:0] poly = 9'h107;
    logic [7:0] r;
    for (int i = 0; i < n; i++) m.push_back(exp_bits[i]);
    repeat (8) m.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (m[i]) for (int j = 0; j < 9; j++) m[i+j] = m[i+j] ^ poly[8-j];
    for (int j = 0; j < 8; j++) r[7-j] = m[n+j];
    return r;
  endfunction

  function automatic logic [7:0] exp_crc(input int n);
`ifdef CONFIG_LOADER_CRC_EN
    return crc_ref(n);
`else
    return (n < 0) ? 8'hFF : 8'h00;
`endif
  endfunction

  function automatic bit bits_ok();
    if (got.size() != exp_bits.size()) return 1'b0;
    foreach (got[i]) if (got[i] !== exp_bits[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction

  task automatic do_load(input int gap);
    int k;
    got.delete();
    busy_cycles = 0; bad_data = 0; bad_ready = 0; gap_bad = 0; timeouts = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < words.size(); i++) begin
      word_in = words[i];
      word_valid = (gap == 0 || i == 0);
      k = 0;
      do begin @(negedge clk); k++; end while (word_ready !== 1'b1 && k < 100);
      if (word_ready !== 1'b1) timeouts++;
      if (gap > 0 && i > 0) begin
        repeat (gap) begin
          @(negedge clk);
          if (word_ready !== 1'b1 || cfg_en !== 1'b0) gap_bad++;
        end
        word_valid = 1'b1;
      end
      @(posedge clk); #1 word_valid = 1'b0;
    end
    k = 0;
    while (done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    if (done !== 1'b1) timeouts++;
    #1;
  endtask

  task automatic test_reset();
    config_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({word_ready, cfg_data, cfg_en, busy, done, crc_out} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 0", {word_ready, cfg_data, cfg_en, busy, done, crc_out});
    end
    n_checks++;
    if ({ready_s, data_s, en_s, busy_s, done_s, crc_s} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_short: got %b, required 0", {ready_s, data_s, en_s, busy_s, done_s, crc_s});
    end
    @(posedge clk); #1 config_rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] crc_done;
    words = '{8'hA5, 8'h3C, 8'hF0};
    build_exp(CL);
    do_load(0);
    n_checks++;
    if (timeouts != 0) begin n_fail++; $display("FAIL b2b_timeout: got %0d timeouts, required 0", timeouts); end
    n_checks++;
    if (pack(got) !== 32'hA53CF) begin
      n_fail++; $display("FAIL b2b_bits: got %h (%0d bits), required a53cf (20 bits)", pack(got), got.size());
    end
    n_checks++;
    if (got.size() != CL) begin n_fail++; $display("FAIL b2b_en_cycles: got %0d, required %0d", got.size(), CL); end
    n_checks++;
    if (busy_cycles != 3 + CL) begin n_fail++; $display("FAIL b2b_throughput: got %0d busy cycles, required %0d", busy_cycles, 3 + CL); end
    n_checks++;
    if (bad_data != 0 || bad_ready != 0) begin
      n_fail++; $display("FAIL b2b_idle_outputs: got data_err=%0d ready_err=%0d, required 0", bad_data, bad_ready);
    end
    n_checks++;
    if (crc_out !== exp_crc(CL)) begin n_fail++; $display("FAIL b2b_crc: got %h, required %h", crc_out, exp_crc(CL)); end
    crc_done = crc_out;
    word_in = 8'hFF; word_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || word_ready !== 1'b0 || crc_out !== crc_done) begin
      n_fail++; $display("FAIL done_hold: got done=%b busy=%b ready=%b crc=%h, required 1 0 0 %h", done, busy, word_ready, crc_out, crc_done);
    end
    word_valid = 1'b0;
  endtask

  task automatic test_gap();
    words = '{8'hA5, 8'h3C, 8'hF0};
    build_exp(CL);
    do_load(5);
    n_checks++;
    if (!bits_ok() || timeouts != 0) begin
      n_fail++; $display("FAIL gap_bits: got %h (%0d bits, %0d timeouts), required a53cf", pack(got), got.size(), timeouts);
    end
    n_checks++;
    if (gap_bad != 0) begin n_fail++; $display("FAIL gap_ready_en: got %0d bad gap cycles, required 0", gap_bad); end
    n_checks++;
    if (busy_cycles != 3 + 2 * 5 + CL) begin
      n_fail++; $display("FAIL gap_busy: got %0d, required %0d", busy_cycles, 3 + 10 + CL);
    end
  endtask

  task automatic test_reset_mid_load();
    int k;
    words = '{8'hA5, 8'h3C, 8'hF0};
    build_exp(CL);
    got.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; word_in = words[0]; word_valid = 1'b1;
    @(posedge clk); #1 word_in = words[1];
    k = 0;
    while (got.size() < 10 && k < 100) begin @(negedge clk); #1; k++; end
    config_rst = 1'b1; word_valid = 1'b0;
    @(posedge clk); #1 config_rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (got.size() != 10 || cfg_en !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort: got bits=%0d en=%b busy=%b ready=%b done=%b, required 10 0 0 0 0", got.size(), cfg_en, busy, word_ready, done);
    end
    do_load(0);
    n_checks++;
    if (!bits_ok() || timeouts != 0) begin
      n_fail++; $display("FAIL reload_bits: got %h (%0d bits), required a53cf (20 bits)", pack(got), got.size());
    end
    n_checks++;
    if (crc_out !== exp_crc(CL)) begin n_fail++; $display("FAIL reload_crc: got %h, required %h", crc_out, exp_crc(CL)); end
  endtask

  task automatic test_ignored();
    int viol = 0;
    config_rst = 1'b1;
    @(posedge clk); #1 config_rst = 1'b0;
    word_in = 8'hFF; word_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || word_ready !== 1'b0 || cfg_en !== 1'b0 || done !== 1'b0) viol++;
    end
    word_valid = 1'b0;
    n_checks++;
    if (viol != 0) begin n_fail++; $display("FAIL idle_valid: got %0d state changes, required 0", viol); end
    words = '{8'h5A, 8'hC3, 8'h0F};
    build_exp(CL);
    fork
      do_load(0);
      begin
        int k = 0;
        do begin @(negedge clk); #1; k++; end while (got.size() < 5 && k < 100);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    n_checks++;
    if (!bits_ok() || busy_cycles != 3 + CL || timeouts != 0) begin
      n_fail++; $display("FAIL start_in_shift: got %h (%0d bits, busy %0d), required %h (20 bits, busy %0d)", pack(got), got.size(), busy_cycles, pack(exp_bits), 3 + CL);
    end
  endtask

  task automatic test_random();
    int gap;
    for (int it = 0; it < 6; it++) begin
      words = '{};
      repeat (3) words.push_back(W'($urandom_range(0, 255)));
      gap = $urandom_range(0, 3);
      build_exp(CL);
      do_load(gap);
      n_checks++;
      if (!bits_ok() || timeouts != 0) begin
        n_fail++; $display("FAIL rand_bits[%0d]: got %h (%0d bits), required %h", it, pack(got), got.size(), pack(exp_bits));
      end
      n_checks++;
      if (busy_cycles != 3 + 2 * gap + CL || gap_bad != 0 || bad_data != 0) begin
        n_fail++; $display("FAIL rand_timing[%0d]: got busy=%0d gap_err=%0d data_err=%0d, required %0d 0 0", it, busy_cycles, gap_bad, bad_data, 3 + 2 * gap + CL);
      end
      n_checks++;
      if (crc_out !== exp_crc(CL)) begin n_fail++; $display("FAIL rand_crc[%0d]: got %h, required %h", it, crc_out, exp_crc(CL)); end
    end
  endtask

  task automatic test_crc_short();
    logic [W-1:0] wl[3];
    logic [7:0] req;
    int k;
    wl[0] = 8'h01; wl[1] = 8'h00; wl[2] = W'($urandom_range(0, 255));
    for (int c = 0; c < 3; c++) begin
      words = '{wl[c]};
      build_exp(CL8);
`ifdef CONFIG_LOADER_CRC_EN
      req = (c == 0) ? 8'h07 : (c == 1) ? 8'h00 : crc_ref(CL8);
`else
      req = 8'h00;
`endif
      @(posedge clk); #1 start_s = 1'b1;
      @(posedge clk); #1 start_s = 1'b0; word_s = wl[c]; valid_s = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (ready_s !== 1'b1 && k < 100);
      @(posedge clk); #1 valid_s = 1'b0;
      k = 0;
      while (done_s !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      n_checks++;
      if (done_s !== 1'b1 || crc_s !== req) begin
        n_fail++; $display("FAIL crc_short[%0d]: got done=%b crc=%h, required 1 %h", c, done_s, crc_s, req);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_reset_mid_load();
    test_ignored();
    test_random();
    test_crc_short();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
